imem_loader: RTL and testbench

Hardware program loader: the writer end of the instruction-memory interface the CPU fetches from. Accepts a stream of 32-bit instruction words on a valid/ready handshake and writes them to consecutive IMem word addresses from 0. Holds the CPU in reset during the load, then releases it after a fixed delay. Replaces bench-side $readmemh preload for hardware/bring-up flows.

---
 rtl/imem_loader_pkg.sv | 17 +
 rtl/loader_csum.sv | 27 ++
 rtl/imem_loader.sv | 119 +++++++++++
 tb/tb_imem_loader.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - loader state encodings and default geometry shared by the loader files
package imem_loader_pkg;

  typedef enum logic [2:0] {
    LD_LOAD  = 3'd0,
    LD_HOLD  = 3'd1,
    LD_RUN   = 3'd2,
    LD_CHECK = 3'd3,
    LD_ERROR = 3'd4
  } ld_state_t;

  localparam int DEF_DATA_WIDTH    = 32;
  localparam int DEF_DEPTH         = 32;
  localparam int DEF_ADDR_WIDTH    = 5;
  localparam int DEF_RELEASE_DELAY = 4;

endpackage

// File: rtl/loader_csum.sv
// rtl/loader_csum.sv - running mod-2^32 sum of written words and compare against the expected sum
module loader_csum
  import imem_loader_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  add_en,
  input  logic [DATA_WIDTH-1:0] add_data,
  input  logic [DATA_WIDTH-1:0] cmp_data,
  output logic                  match
);

  logic [31:0] sum;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sum <= '0;
    end else if (add_en) begin
      sum <= sum + 32'(add_data);
    end
  end

  assign match = (sum == 32'(cmp_data));

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - streams words into IMem from address 0, holds the CPU in reset, then releases it
// Optional checksum beat after the program: define LOADER_CHECKSUM_EN.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int DEPTH         = DEF_DEPTH,
  parameter int ADDR_WIDTH    = DEF_ADDR_WIDTH,
  parameter int RELEASE_DELAY = DEF_RELEASE_DELAY
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [DATA_WIDTH-1:0] imem_wdata,
  output logic                  cpu_reset,
  output logic                  done,
  output logic                  truncated,
  output logic                  error
);

  localparam int DLY_W = $clog2(RELEASE_DELAY + 2);

  ld_state_t             state;
  logic [ADDR_WIDTH-1:0] cnt;
  logic [DLY_W-1:0]      dly;
  logic                  beat;

  // Reset gating keeps the stream stalled while the loader is held in reset.
  assign in_ready = reset & ((state == LD_LOAD) | (state == LD_CHECK));
  assign beat     = in_valid & in_ready;

`ifdef LOADER_CHECKSUM_EN
  logic csum_match;
  logic err_q;

  loader_csum #(.DATA_WIDTH(DATA_WIDTH)) u_csum (
    .clock    (clock),
    .reset    (reset),
    .add_en   (beat && (state == LD_LOAD)),
    .add_data (in_data),
    .cmp_data (in_data),
    .match    (csum_match)
  );

  assign error = err_q;
`else
  assign error = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= LD_LOAD;
      cnt        <= '0;
      dly        <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      cpu_reset  <= 1'b0;
      done       <= 1'b0;
      truncated  <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      err_q      <= 1'b0;
`endif
    end else begin
      imem_we <= 1'b0;
      case (state)
        LD_LOAD: begin
          if (beat) begin
            imem_we    <= 1'b1;
            imem_addr  <= cnt;
            imem_wdata <= in_data;
            // The counter stops at the last entry instead of wrapping.
            if (in_last || (cnt == ADDR_WIDTH'(DEPTH - 1))) begin
              truncated <= ~in_last;
`ifdef LOADER_CHECKSUM_EN
              state     <= LD_CHECK;
`else
              state     <= LD_HOLD;
              dly       <= DLY_W'(RELEASE_DELAY);
`endif
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        LD_HOLD: begin
          // Entering HOLD coincides with the final write, so release lands
          // RELEASE_DELAY edges after that write edge.
          dly <= dly - 1'b1;
          if (dly <= DLY_W'(1)) begin
            state     <= LD_RUN;
            cpu_reset <= 1'b1;
            done      <= 1'b1;
          end
        end
`ifdef LOADER_CHECKSUM_EN
        LD_CHECK: begin
          if (beat) begin
            if (csum_match) begin
              state <= LD_HOLD;
              dly   <= DLY_W'(RELEASE_DELAY);
            end else begin
              state <= LD_ERROR;
              err_q <= 1'b1;
            end
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - randomized self-checking bench for imem_loader against a queue-based load model
module tb_imem_loader;

  localparam int DEPTH = 32;
  localparam int RDLY  = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_ready;
  logic        imem_we;
  logic [4:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_reset;
  logic        done;
  logic        truncated;
  logic        error;

  imem_loader dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_reset  (cpu_reset),
    .done       (done),
    .truncated  (truncated),
    .error      (error)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Write monitor: every IMem write observed after an edge, plus the release edge.
  int          cyc = 0;
  int          wr_cyc = -1;
  int          rise_cyc = -1;
  logic        prev_cr = 1'b0;
  logic [4:0]  cap_addr[$];
  logic [31:0] cap_data[$];

  always @(posedge clock) begin
    #1;
    cyc++;
    if (imem_we === 1'b1) begin
      cap_addr.push_back(imem_addr);
      cap_data.push_back(imem_wdata);
      wr_cyc = cyc;
    end
    if (cpu_reset === 1'b1 && !prev_cr) rise_cyc = cyc;
    prev_cr = cpu_reset;
  end

  logic [31:0] words[$];

  task automatic do_reset();
    @(negedge clock);
    reset    = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    repeat (2) @(negedge clock);
    cap_addr.delete();
    cap_data.delete();
    wr_cyc   = -1;
    rise_cyc = -1;
    reset    = 1'b1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_we"},        imem_we,    0);
    check({tag, "_addr"},      imem_addr,  0);
    check({tag, "_wdata"},     imem_wdata, 0);
    check({tag, "_cpu_reset"}, cpu_reset,  0);
    check({tag, "_done"},      done,       0);
    check({tag, "_trunc"},     truncated,  0);
    check({tag, "_error"},     error,      0);
    check({tag, "_ready"},     in_ready,   0);
  endtask

  // gap_pct < 0 alternates valid 1,0,1,0,...; bad_sum only matters with the checksum beat.
  task automatic load(input string tag, input int last_idx, input int gap_pct, input int bad_sum);
    int          n;
    int          exp_n;
    int          i;
    int          budget;
    bit          tog;
    bit          trunc_exp;
    logic [31:0] sum;
    n     = words.size();
    exp_n = n;
    if (last_idx >= 0 && last_idx + 1 < exp_n) exp_n = last_idx + 1;
    if (exp_n > DEPTH) exp_n = DEPTH;
    trunc_exp = !(last_idx >= 0 && last_idx < exp_n);
    sum = '0;
    for (int k = 0; k < exp_n; k++) sum += words[k];
    i = 0;
    budget = 0;
    tog = 1'b1;
    while (i < exp_n && budget < 2000) begin
      @(negedge clock);
      budget++;
      in_valid = (gap_pct < 0) ? tog : ($urandom_range(99) >= gap_pct);
      tog      = ~tog;
      in_data  = words[i];
      in_last  = (i == last_idx);
      if (in_valid && in_ready) i++;
    end
    check({tag, "_accepted"}, i, exp_n);
    // Offer one more word: refused by default, taken as the checksum with the feature.
    @(negedge clock);
    in_valid = 1'b1;
    in_last  = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    in_data  = sum + bad_sum;
    check({tag, "_csum_ready"}, in_ready, 1);
`else
    in_data  = (exp_n < n) ? words[exp_n] : 32'hdeadbeef;
    check({tag, "_extra_ready"}, in_ready, 0);
`endif
    @(negedge clock);
    in_valid = 1'b0;
    budget = 0;
    while (!done && !error && budget < 100) begin
      @(negedge clock);
      budget++;
    end
    if (bad_sum != 0) begin
      repeat (25) @(negedge clock);
      check({tag, "_err"},       error,     1);
      check({tag, "_err_cpu"},   cpu_reset, 0);
      check({tag, "_err_done"},  done,      0);
      check({tag, "_err_ready"}, in_ready,  0);
    end else begin
      check({tag, "_done"},      done,      1);
      check({tag, "_cpu_reset"}, cpu_reset, 1);
      check({tag, "_trunc"},     truncated, trunc_exp);
      check({tag, "_error"},     error,     0);
      check({tag, "_ready"},     in_ready,  0);
      check({tag, "_we_idle"},   imem_we,   0);
`ifndef LOADER_CHECKSUM_EN
      check({tag, "_release"},   rise_cyc - wr_cyc, RDLY);
`endif
    end
    check({tag, "_nwrites"}, cap_addr.size(), exp_n);
    for (int k = 0; k < exp_n && k < cap_addr.size(); k++) begin
      check($sformatf("%s_addr%0d", tag, k), cap_addr[k], k);
      check($sformatf("%s_data%0d", tag, k), cap_data[k], words[k]);
    end
  endtask

  initial begin
    repeat (2) @(negedge clock);
    check_idle_outputs("por");
    reset = 1'b1;

    words = '{32'h20100009, 32'h00000000, 32'h2011000A};
    load("basic", 2, 0, 0);

    do_reset();
    load("toggle", 2, -1, 0);

    do_reset();
    words.delete();
    for (int k = 0; k < 33; k++) words.push_back($urandom);
    load("trunc", -1, 0, 0);

    do_reset();
    words = '{32'h0000000C};
    load("single", 0, 0, 0);

    // Abandon a load after two beats, then restart from address 0.
    do_reset();
    for (int k = 0; k < 2; k++) begin
      @(negedge clock);
      in_valid = 1'b1;
      in_data  = 32'hA5A50000 + k;
      in_last  = 1'b0;
    end
    @(negedge clock);
    in_valid = 1'b0;
    check("midrst_we_before", imem_we, 1);
    reset = 1'b0;
    #1;
    check_idle_outputs("midrst");
    do_reset();
    words.delete();
    for (int k = 0; k < 5; k++) words.push_back($urandom);
    load("restart", 4, 0, 0);

    for (int r = 0; r < 6; r++) begin
      int n;
      int li;
      do_reset();
      n = $urandom_range(1, 40);
      words.delete();
      for (int k = 0; k < n; k++) words.push_back($urandom);
      li = (n > DEPTH && $urandom_range(1) == 1) ? -1 : $urandom_range(0, n - 1);
      load($sformatf("rnd%0d", r), li, $urandom_range(0, 60), 0);
    end

`ifdef LOADER_CHECKSUM_EN
    do_reset();
    words = '{32'd1, 32'd2, 32'd3};
    load("csum_ok", 2, 0, 0);
    do_reset();
    load("csum_bad", 2, 0, 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
